mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and burst sequencer between the fetch stage (instruction requester) and the memory stage (data requester) of the pipelined processor. Grants the shared synchronous main memory to one requester at a time, expands each request into 1/4/8/16 single-word beats, returns read data, and drives each requester's stall until its transaction completes. The fetch unit's `stall_in` is driven from `if_stall_out`.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, word width; one beat = one word.

- `clk_in`  in  1  clock; all state updates on rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `if_req_in`  in  1  fetch request; held until its final `if_valid_out`.
- `if_addr_in`  in  ADDR_WIDTH  fetch start address; bits [1:0] ignored.
- `if_access_size_in`  in  2  burst length: 00=1, 01=4, 10=8, 11=16 words.
- `if_rdata_out`  out  DATA_WIDTH  fetch read data.
- `if_valid_out`  out  1  one pulse per returned fetch word.
- `if_stall_out`  out  1  fetch must hold.
- `mem_req_in`  in  1  data request; held until its final `mem_valid_out`.
- `mem_rw_in`  in  1  1 = write, 0 = read.
- `mem_addr_in`  in  ADDR_WIDTH  data start address; bits [1:0] ignored.
- `mem_access_size_in`  in  2  burst length, same encoding.
- `mem_wdata_in`  in  DATA_WIDTH  write word for current beat.
- `mem_rdata_out`  out  DATA_WIDTH  data read word.
- `mem_valid_out`  out  1  read: word returned; write: beat consumed.
- `mem_stall_out`  out  1  memory stage must hold.
- `ram_en_out`  out  1  beat issued this cycle.
- `ram_rw_out`  out  1  1 = write beat.
- `ram_addr_out`  out  ADDR_WIDTH  beat word address, bits [1:0] = 00.
- `ram_wdata_out`  out  DATA_WIDTH  write data for beat.
- `ram_rdata_in`  in  DATA_WIDTH  read data, valid exactly 1 cycle after a read beat.

## Operation
- States: IDLE, BURST, RDWAIT. Registers: owner (IF/MEM), rw, beat address, beat counter (4 bits), `last_mem` (last grant went to MEM).
- IDLE: samples requests. Only one pending -> grant it. Both pending -> grant MEM unless `last_mem`=1, then grant IF (strict alternation under contention). Latch owner, rw (IF always read), start address with [1:0] cleared, count = beats-1; update `last_mem`; go BURST. No request -> stay.
- BURST: `ram_en_out`=1, `ram_addr_out`=beat address, `ram_rw_out`=rw, `ram_wdata_out`=`mem_wdata_in` (writes). Address += 4 per beat, wraps modulo 2^ADDR_WIDTH. Count 0 on a write beat -> IDLE; on a read beat -> RDWAIT; else decrement.
- RDWAIT: last read word returns; -> IDLE.
- Read data: owner's valid pulses the cycle after each read beat; rdata = `ram_rdata_in`. Non-owner valid = 0. Write: `mem_valid_out` = 1 in each write-beat cycle; requester presents next word the following cycle.
- Stall: `x_stall_out` = `x_req_in` AND NOT (x owns and final valid asserts this cycle). Combinational.
- Request inputs are not re-sampled after grant; changes mid-burst are ignored.
- Reset: state IDLE, `last_mem`=0, counter/address 0. Mid-burst reset aborts with no further beats or valids.

## Timing
- Reset values: `ram_en_out`, `ram_rw_out`, `if_valid_out`, `mem_valid_out` = 0; `ram_addr_out`, `ram_wdata_out`, rdata outputs = 0; stalls = their req inputs.
- Read of N words, req seen in IDLE at cycle 0: beats cycles 1..N, valids cycles 2..N+1, stall low cycle N+1, IDLE cycle N+2. Single word: valid cycle 2.
- Write of N words: beats/valids cycles 1..N, stall low cycle N, IDLE cycle N+1.
- Minimum one IDLE cycle between transactions; a request raised in the cycle the previous one finishes is granted at the next IDLE.

## Test plan
- IF single read 0x00000104, RAM returns word at 0x104: beat cycle 1 addr 0x00000104, `if_valid_out` cycle 2 only, `if_stall_out` high cycles 0-1, low cycle 2.
- IF 4-word read at 0x00000103: beat addresses 0x100,0x104,0x108,0x10C cycles 1-4; valids cycles 2-5; `mem_stall_out` stays 0 with no mem request.
- MEM 8-word write at 0xFFFFFFF8: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000..0x00000014; `ram_rw_out`=1, `mem_valid_out` each beat, stall low cycle 8.
- Both requesting continuously, size 00 reads: grants alternate MEM, IF, MEM, IF starting with MEM after reset; non-owner never sees valid.
- `rst_in` during beat 3 of a 16-word IF read: next cycle `ram_en_out`=0, no valids, state IDLE; pending MEM request granted first afterwards.
- Owner changes `if_addr_in` mid-burst: beat addresses unaffected.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the arbiter, its two requesters
// (fetch and memory stage) and the shared single-port main memory.
//
// Signal groups:
//   fetch  : if_req_in, if_addr_in, if_access_size_in -> if_rdata_out,
//            if_valid_out, if_stall_out
//   data   : mem_req_in, mem_rw_in, mem_addr_in, mem_access_size_in,
//            mem_wdata_in -> mem_rdata_out, mem_valid_out, mem_stall_out
//   memory : ram_en_out, ram_rw_out, ram_addr_out, ram_wdata_out <- ram_rdata_in
//
// Modports:
//   slave  : the arbiter (consumes *_in, drives *_out)
//   master : requesters plus memory (drive *_in, observe *_out)
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // fetch requester
  logic                  if_req_in;
  logic [ADDR_WIDTH-1:0] if_addr_in;
  logic [1:0]            if_access_size_in;
  logic [DATA_WIDTH-1:0] if_rdata_out;
  logic                  if_valid_out;
  logic                  if_stall_out;
  // data requester
  logic                  mem_req_in;
  logic                  mem_rw_in;
  logic [ADDR_WIDTH-1:0] mem_addr_in;
  logic [1:0]            mem_access_size_in;
  logic [DATA_WIDTH-1:0] mem_wdata_in;
  logic [DATA_WIDTH-1:0] mem_rdata_out;
  logic                  mem_valid_out;
  logic                  mem_stall_out;
  // main memory
  logic                  ram_en_out;
  logic                  ram_rw_out;
  logic [ADDR_WIDTH-1:0] ram_addr_out;
  logic [DATA_WIDTH-1:0] ram_wdata_out;
  logic [DATA_WIDTH-1:0] ram_rdata_in;

  modport slave (
    input  if_req_in, if_addr_in, if_access_size_in,
    output if_rdata_out, if_valid_out, if_stall_out,
    input  mem_req_in, mem_rw_in, mem_addr_in, mem_access_size_in, mem_wdata_in,
    output mem_rdata_out, mem_valid_out, mem_stall_out,
    output ram_en_out, ram_rw_out, ram_addr_out, ram_wdata_out,
    input  ram_rdata_in
  );

  modport master (
    output if_req_in, if_addr_in, if_access_size_in,
    input  if_rdata_out, if_valid_out, if_stall_out,
    output mem_req_in, mem_rw_in, mem_addr_in, mem_access_size_in, mem_wdata_in,
    input  mem_rdata_out, mem_valid_out, mem_stall_out,
    input  ram_en_out, ram_rw_out, ram_addr_out, ram_wdata_out,
    output ram_rdata_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter and burst sequencer shared by the
// fetch stage (read-only) and the memory stage (read/write).
//
// Ports:
//   clk_in : clock, all state on the rising edge
//   rst_in : synchronous active-high reset
//   bus    : mem_arbiter_if.slave (fetch, data and memory signal groups)
//
// One grant at a time; each grant is expanded into 1/4/8/16 single-word
// beats on consecutive cycles. Read data comes back one cycle after each
// read beat, so a read burst ends with one extra RDWAIT cycle. Under
// contention grants alternate, with MEM winning the first tie after reset.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk_in,
  input  logic           rst_in,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_RDWAIT} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  // Attributes latched at grant time; requester inputs are not looked at
  // again until the next IDLE.
  typedef struct packed {
    owner_t owner;
    logic   rw;
  } grant_t;

  state_t                state_q, state_d;
  grant_t                grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  last_mem_q, last_mem_d;
  logic                  rd_vld_q;   // a read beat was issued last cycle

  // Beats remaining after the first one.
  function automatic logic [3:0] size_to_cnt(input logic [1:0] sz);
    case (sz)
      2'b00:   size_to_cnt = 4'd0;
      2'b01:   size_to_cnt = 4'd3;
      2'b10:   size_to_cnt = 4'd7;
      default: size_to_cnt = 4'd15;
    endcase
  endfunction

  // Word-align: low address bits are ignored.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic grant_mem;
  assign grant_mem = bus.mem_req_in && (!bus.if_req_in || !last_mem_q);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    last_mem_d = last_mem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.if_req_in || bus.mem_req_in) begin
          state_d    = S_BURST;
          last_mem_d = grant_mem;
          if (grant_mem) begin
            grant_d.owner = OWN_MEM;
            grant_d.rw    = bus.mem_rw_in;
            addr_d        = bus.mem_addr_in & ALIGN_MASK;
            cnt_d         = size_to_cnt(bus.mem_access_size_in);
          end else begin
            grant_d.owner = OWN_IF;
            grant_d.rw    = 1'b0;       // fetch never writes
            addr_d        = bus.if_addr_in & ALIGN_MASK;
            cnt_d         = size_to_cnt(bus.if_access_size_in);
          end
        end
      end
      S_BURST: begin
        // Wraps naturally at the top of the address space.
        addr_d = addr_q + ADDR_WIDTH'(4);
        if (cnt_q == 4'd0) begin
          // Writes finish with the last beat; reads need one more cycle
          // for the final word to come back.
          state_d = grant_q.rw ? S_IDLE : S_RDWAIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RDWAIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      grant_q    <= '{owner: OWN_IF, rw: 1'b0};
      addr_q     <= '0;
      cnt_q      <= 4'd0;
      last_mem_q <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      last_mem_q <= last_mem_d;
      rd_vld_q   <= (state_q == S_BURST) && !grant_q.rw;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic beat, wr_beat, final_vld, if_own, mem_own;

  assign beat    = (state_q == S_BURST);
  assign wr_beat = beat && grant_q.rw;
  assign if_own  = (grant_q.owner == OWN_IF);
  assign mem_own = (grant_q.owner == OWN_MEM);

  // The owner's last valid: last write beat, or the word returning in RDWAIT.
  assign final_vld = (state_q == S_RDWAIT) || (wr_beat && (cnt_q == 4'd0));

  assign bus.ram_en_out    = beat;
  assign bus.ram_rw_out    = wr_beat;
  assign bus.ram_addr_out  = beat ? addr_q : {ADDR_WIDTH{1'b0}};
  assign bus.ram_wdata_out = wr_beat ? bus.mem_wdata_in : {DATA_WIDTH{1'b0}};

  // Only a MEM grant can produce write beats, so wr_beat needs no owner term.
  assign bus.if_valid_out  = if_own && rd_vld_q;
  assign bus.mem_valid_out = (mem_own && rd_vld_q) || wr_beat;

  assign bus.if_rdata_out  = bus.if_valid_out ? bus.ram_rdata_in : {DATA_WIDTH{1'b0}};
  assign bus.mem_rdata_out = (mem_own && rd_vld_q) ? bus.ram_rdata_in : {DATA_WIDTH{1'b0}};

  assign bus.if_stall_out  = bus.if_req_in  && !(if_own  && final_vld);
  assign bus.mem_stall_out = bus.mem_req_in && !(mem_own && final_vld);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] mdat(input logic [31:0] a);
    mdat = {a[15:0], ~a[15:0]};
  endfunction

  // Synchronous memory: read data one cycle after a read beat.
  always @(posedge clk_in)
    if (bus.ram_en_out && !bus.ram_rw_out) bus.ram_rdata_in <= mdat(bus.ram_addr_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (inputs are driven here).
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // IF read of n words; start address a, aligned base, mem_req kept at 0.
  task automatic if_read(input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] base, input int n);
    cyc();
    bus.if_req_in = 1'b1; bus.if_addr_in = a; bus.if_access_size_in = sz;
    settle();
    chk("rd_c0_en", 32'(bus.ram_en_out), 32'd0);
    chk("rd_c0_stall", 32'(bus.if_stall_out), 32'd1);
    for (int k = 1; k <= n; k++) begin
      cyc();
      if (k == 2) bus.if_addr_in = 32'hDEAD_BEE0;   // must be ignored
      settle();
      chk("rd_beat_en", 32'(bus.ram_en_out), 32'd1);
      chk("rd_beat_rw", 32'(bus.ram_rw_out), 32'd0);
      chk("rd_beat_addr", bus.ram_addr_out, base + 32'(4 * (k - 1)));
      chk("rd_beat_vld", 32'(bus.if_valid_out), (k > 1) ? 32'd1 : 32'd0);
      if (k > 1) chk("rd_beat_data", bus.if_rdata_out, mdat(base + 32'(4 * (k - 2))));
      chk("rd_beat_stall", 32'(bus.if_stall_out), 32'd1);
      chk("rd_beat_mvld", 32'(bus.mem_valid_out), 32'd0);
      chk("rd_beat_mstall", 32'(bus.mem_stall_out), 32'd0);
    end
    cyc();
    settle();
    chk("rd_last_en", 32'(bus.ram_en_out), 32'd0);
    chk("rd_last_vld", 32'(bus.if_valid_out), 32'd1);
    chk("rd_last_data", bus.if_rdata_out, mdat(base + 32'(4 * (n - 1))));
    chk("rd_last_stall", 32'(bus.if_stall_out), 32'd0);
    cyc();
    bus.if_req_in = 1'b0;
    settle();
    chk("rd_idle_en", 32'(bus.ram_en_out), 32'd0);
    chk("rd_idle_vld", 32'(bus.if_valid_out), 32'd0);
  endtask

  initial begin
    bus.if_req_in = 0; bus.if_addr_in = 0; bus.if_access_size_in = 0;
    bus.mem_req_in = 0; bus.mem_rw_in = 0; bus.mem_addr_in = 0;
    bus.mem_access_size_in = 0; bus.mem_wdata_in = 0; bus.ram_rdata_in = 0;

    // ---- reset state ----
    cyc();
    cyc();
    bus.mem_req_in = 1'b1; bus.mem_wdata_in = 32'h1234_5678;
    settle();
    chk("rst_en", 32'(bus.ram_en_out), 32'd0);
    chk("rst_rw", 32'(bus.ram_rw_out), 32'd0);
    chk("rst_addr", bus.ram_addr_out, 32'd0);
    chk("rst_wdata", bus.ram_wdata_out, 32'd0);
    chk("rst_ivld", 32'(bus.if_valid_out), 32'd0);
    chk("rst_mvld", 32'(bus.mem_valid_out), 32'd0);
    chk("rst_irdata", bus.if_rdata_out, 32'd0);
    chk("rst_mrdata", bus.mem_rdata_out, 32'd0);
    chk("rst_mstall", 32'(bus.mem_stall_out), 32'd1);
    chk("rst_istall", 32'(bus.if_stall_out), 32'd0);
    cyc();
    rst_in = 1'b0; bus.mem_req_in = 1'b0; bus.mem_wdata_in = 0;

    // ---- IF single read, IF 4-word unaligned read ----
    if_read(32'h0000_0104, 2'b00, 32'h0000_0104, 1);
    if_read(32'h0000_0103, 2'b01, 32'h0000_0100, 4);

    // ---- MEM 8-word write wrapping through zero ----
    cyc();
    bus.mem_req_in = 1'b1; bus.mem_rw_in = 1'b1; bus.mem_addr_in = 32'hFFFF_FFF8;
    bus.mem_access_size_in = 2'b10; bus.mem_wdata_in = 32'h1000_0000;
    settle();
    chk("wr_c0_stall", 32'(bus.mem_stall_out), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      bus.mem_wdata_in = 32'h1000_0000 + 32'(k - 1);
      settle();
      chk("wr_en", 32'(bus.ram_en_out), 32'd1);
      chk("wr_rw", 32'(bus.ram_rw_out), 32'd1);
      chk("wr_addr", bus.ram_addr_out, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
      chk("wr_wdata", bus.ram_wdata_out, 32'h1000_0000 + 32'(k - 1));
      chk("wr_vld", 32'(bus.mem_valid_out), 32'd1);
      chk("wr_ivld", 32'(bus.if_valid_out), 32'd0);
      chk("wr_stall", 32'(bus.mem_stall_out), (k == 8) ? 32'd0 : 32'd1);
    end
    cyc();
    bus.mem_req_in = 1'b0; bus.mem_rw_in = 1'b0;
    settle();
    chk("wr_idle_en", 32'(bus.ram_en_out), 32'd0);
    chk("wr_idle_vld", 32'(bus.mem_valid_out), 32'd0);

    // ---- alternation under contention, fresh from reset ----
    cyc();
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      cyc();
      if (c == 0) begin
        bus.mem_req_in = 1'b1; bus.mem_rw_in = 1'b0; bus.mem_access_size_in = 2'b00;
        bus.mem_addr_in = 32'h0000_0200;
        bus.if_req_in = 1'b1; bus.if_access_size_in = 2'b00; bus.if_addr_in = 32'h0000_0300;
      end
      if (c == 12) begin
        bus.mem_req_in = 1'b0; bus.if_req_in = 1'b0;
      end
      settle();
      // three cycles per grant: IDLE, BURST, RDWAIT; MEM, IF, MEM, IF
      if (c % 3 == 1) begin
        chk("alt_en", 32'(bus.ram_en_out), 32'd1);
        chk("alt_addr", bus.ram_addr_out, ((c / 3) % 2 == 0) ? 32'h200 : 32'h300);
      end else if (c % 3 == 2) begin
        chk("alt_mvld", 32'(bus.mem_valid_out), ((c / 3) % 2 == 0) ? 32'd1 : 32'd0);
        chk("alt_ivld", 32'(bus.if_valid_out), ((c / 3) % 2 == 0) ? 32'd0 : 32'd1);
        chk("alt_mstall", 32'(bus.mem_stall_out), ((c / 3) % 2 == 0) ? 32'd0 : 32'd1);
        chk("alt_istall", 32'(bus.if_stall_out), ((c / 3) % 2 == 0) ? 32'd1 : 32'd0);
        if ((c / 3) % 2 == 0) chk("alt_mdata", bus.mem_rdata_out, mdat(32'h200));
        else                  chk("alt_idata", bus.if_rdata_out, mdat(32'h300));
      end else begin
        chk("alt_idle_en", 32'(bus.ram_en_out), 32'd0);
      end
    end

    // ---- reset during beat 3 of a 16-word IF read ----
    cyc();
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h0000_0500; bus.if_access_size_in = 2'b11;
    settle();
    chk("ra_c0_en", 32'(bus.ram_en_out), 32'd0);
    cyc();
    bus.mem_req_in = 1'b1; bus.mem_rw_in = 1'b0; bus.mem_addr_in = 32'h0000_0400;
    bus.mem_access_size_in = 2'b00;
    settle();
    chk("ra_b1_addr", bus.ram_addr_out, 32'h0000_0500);
    chk("ra_b1_mstall", 32'(bus.mem_stall_out), 32'd1);
    cyc();
    settle();
    chk("ra_b2_addr", bus.ram_addr_out, 32'h0000_0504);
    chk("ra_b2_data", bus.if_rdata_out, mdat(32'h0000_0500));
    cyc();
    rst_in = 1'b1;
    settle();
    chk("ra_b3_en", 32'(bus.ram_en_out), 32'd1);
    chk("ra_b3_addr", bus.ram_addr_out, 32'h0000_0508);
    cyc();
    rst_in = 1'b0;
    settle();
    chk("ra_post_en", 32'(bus.ram_en_out), 32'd0);
    chk("ra_post_ivld", 32'(bus.if_valid_out), 32'd0);
    chk("ra_post_mvld", 32'(bus.mem_valid_out), 32'd0);
    chk("ra_post_istall", 32'(bus.if_stall_out), 32'd1);
    cyc();
    settle();
    chk("ra_mem_en", 32'(bus.ram_en_out), 32'd1);
    chk("ra_mem_addr", bus.ram_addr_out, 32'h0000_0400);
    cyc();
    settle();
    chk("ra_mem_vld", 32'(bus.mem_valid_out), 32'd1);
    chk("ra_mem_data", bus.mem_rdata_out, mdat(32'h0000_0400));
    chk("ra_mem_ivld", 32'(bus.if_valid_out), 32'd0);
    chk("ra_mem_stall", 32'(bus.mem_stall_out), 32'd0);
    cyc();
    bus.mem_req_in = 1'b0; bus.if_req_in = 1'b0;
    settle();
    chk("ra_end_en", 32'(bus.ram_en_out), 32'd0);
    cyc();
    settle();
    chk("ra_quiet_en", 32'(bus.ram_en_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
